fir_xifu_ex_simd: RTL and testbench

- Parametrised next-generation execute stage for the FIR XIFU coprocessor.
- Generalises the fixed 2x16-bit dot-product EX stage to XLEN-wide SIMD in two element modes (16-bit, 8-bit), with optional saturation and a configurable MAC pipeline depth.
- Handles post-increment load/store issue to the CV32E40X LSU path, holding stores until commit and supporting kill.
- Sits between the XIFU ID/EX register and the WB stage; valid/ready on both sides.

---
 rtl/fir_xifu_pkg.sv | 33 +++
 rtl/fir_xifu_simd_dotp.sv | 62 ++++++
 rtl/fir_xifu_ex_simd.sv | 179 +++++++++++++++++
 tb/tb_fir_xifu_ex_simd.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_xifu_pkg.sv
// Shared types for the FIR XIFU coprocessor: opcodes, EX-stage FSM states and
// the memory request held while a load/store is presented to the LSU.
package fir_xifu_pkg;

  typedef enum logic [1:0] {
    OpNop   = 2'd0,
    OpLoad  = 2'd1,
    OpStore = 2'd2,
    OpDotp  = 2'd3
  } fir_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StMac,
    StWaitCommit,
    StMem,
    StDone
  } fir_ex_state_e;

  localparam logic Mode16 = 1'b0;
  localparam logic Mode8  = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
  } mem_req_t;

  // Post-increment address: base plus sign-extended 12-bit offset, wrapping at 2^32.
  function automatic logic [31:0] post_inc(input logic [31:0] base, input logic [11:0] imm);
    return base + {{20{imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/fir_xifu_simd_dotp.sv
// Combinational SIMD dot product: signed lane products in 16- or 8-bit lanes,
// summed with the accumulator operand, optionally saturated to XLEN.
module fir_xifu_simd_dotp
  import fir_xifu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [XLEN-1:0] c_i,
  input  logic            mode_i,
  input  logic            sat_i,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned AccW    = XLEN + 4;
  localparam int unsigned Lanes16 = XLEN / 16;
  localparam int unsigned Lanes8  = XLEN / 8;

  logic [AccW-1:0] acc;
  logic [31:0]     ea16, eb16, p16;
  logic [15:0]     ea8, eb8, p8;
  logic            ovf;

  // Operands are sign-extended to twice their width, so the low half of an
  // unsigned product equals the exact signed product.
  always_comb begin
    acc  = {{4{c_i[XLEN-1]}}, c_i};
    ea16 = '0;
    eb16 = '0;
    p16  = '0;
    ea8  = '0;
    eb8  = '0;
    p8   = '0;
    if (mode_i == Mode8) begin
      for (int unsigned i = 0; i < Lanes8; i++) begin
        ea8 = {{8{a_i[8*i+7]}}, a_i[8*i+:8]};
        eb8 = {{8{b_i[8*i+7]}}, b_i[8*i+:8]};
        p8  = ea8 * eb8;
        acc = acc + {{(AccW-16){p8[15]}}, p8};
      end
    end else begin
      for (int unsigned i = 0; i < Lanes16; i++) begin
        ea16 = {{16{a_i[16*i+15]}}, a_i[16*i+:16]};
        eb16 = {{16{b_i[16*i+15]}}, b_i[16*i+:16]};
        p16  = ea16 * eb16;
        acc  = acc + {{(AccW-32){p16[31]}}, p16};
      end
    end
  end

  // Result fits in XLEN only if the bits above the XLEN sign bit are a pure sign extension.
  assign ovf = ~(&acc[AccW-1:XLEN-1]) & (|acc[AccW-1:XLEN-1]);

  always_comb begin
    result_o = acc[XLEN-1:0];
    if (sat_i && ovf) begin
      result_o = acc[AccW-1] ? {1'b1, {(XLEN-1){1'b0}}} : {1'b0, {(XLEN-1){1'b1}}};
    end
  end

endmodule

// File: rtl/fir_xifu_ex_simd.sv
// FIR XIFU execute stage: SIMD dot product with modelled MAC latency and
// post-increment load/store issue with commit/kill handling for stores.
module fir_xifu_ex_simd
  import fir_xifu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MAC_LAT = 1,
  parameter int unsigned ID_W    = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [1:0]      in_op_i,
  input  logic            in_mode_i,
  input  logic            in_sat_i,
  input  logic [ID_W-1:0] in_id_i,
  input  logic [4:0]      in_rd_i,
  input  logic [4:0]      in_rs1_i,
  input  logic [XLEN-1:0] in_base_i,
  input  logic [11:0]     in_imm_i,
  input  logic [4:0]      in_shamt_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic [XLEN-1:0] op_c_i,
  input  logic            commit_valid_i,
  input  logic [ID_W-1:0] commit_id_i,
  input  logic            commit_kill_i,
  input  logic            fwd_we_i,
  input  logic [4:0]      fwd_rd_i,
  input  logic [XLEN-1:0] fwd_result_i,
  output logic            mem_valid_o,
  input  logic            mem_ready_i,
  output logic [31:0]     mem_addr_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [ID_W-1:0] mem_id_o,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [1:0]      out_op_o,
  output logic [4:0]      out_rd_o,
  output logic [ID_W-1:0] out_id_o,
  output logic [XLEN-1:0] out_result_o,
  output logic [31:0]     out_next_addr_o
);

  // Accept itself is one cycle, so the counter covers only the remaining MAC cycles.
  localparam logic [1:0] MacCnt = (MAC_LAT > 1) ? 2'(MAC_LAT - 2) : 2'd0;

  fir_ex_state_e   state_q;
  fir_op_e         op_q;
  logic [4:0]      rd_q;
  logic [ID_W-1:0] id_q;
  mem_req_t        req_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] result_q;
  logic [31:0]     next_addr_q;
  logic [1:0]      cnt_q;

  fir_op_e         in_op;
  logic [XLEN-1:0] base_full;
  logic [31:0]     base;
  logic [XLEN-1:0] dotp_result;
  logic [XLEN-1:0] store_data;
  logic            accept_commit;
  logic            wait_hit;

  assign in_op         = fir_op_e'(in_op_i);
  assign base_full     = (fwd_we_i && (fwd_rd_i == in_rs1_i)) ? fwd_result_i : in_base_i;
  assign base          = base_full[31:0];
  assign store_data    = $signed(op_c_i) >>> in_shamt_i;
  assign accept_commit = commit_valid_i && (commit_id_i == in_id_i) && !commit_kill_i;
  assign wait_hit      = commit_valid_i && (commit_id_i == id_q);

  fir_xifu_simd_dotp #(
    .XLEN(XLEN)
  ) u_dotp (
    .a_i     (op_a_i),
    .b_i     (op_b_i),
    .c_i     (op_c_i),
    .mode_i  (in_mode_i),
    .sat_i   (in_sat_i),
    .result_o(dotp_result)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q     <= StIdle;
      op_q        <= OpNop;
      rd_q        <= '0;
      id_q        <= '0;
      req_q       <= '0;
      wdata_q     <= '0;
      result_q    <= '0;
      next_addr_q <= '0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            op_q        <= in_op;
            rd_q        <= in_rd_i;
            id_q        <= in_id_i;
            req_q.addr  <= base;
            req_q.we    <= (in_op == OpStore);
            wdata_q     <= store_data;
            result_q    <= (in_op == OpDotp) ? dotp_result : '0;
            next_addr_q <= ((in_op == OpLoad) || (in_op == OpStore)) ?
                           post_inc(base, in_imm_i) : '0;
            cnt_q       <= MacCnt;
            unique case (in_op)
              OpNop:   state_q <= StDone;
              OpDotp:  state_q <= (MAC_LAT > 1) ? StMac : StDone;
              OpLoad:  state_q <= StMem;
              OpStore: state_q <= accept_commit ? StMem : StWaitCommit;
              default: state_q <= StIdle;
            endcase
          end
        end
        StMac: begin
          if (cnt_q == 2'd0) begin
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        StWaitCommit: begin
          // Kill takes priority over commit when both name this id.
          if (wait_hit) begin
            state_q <= commit_kill_i ? StIdle : StMem;
          end
        end
        StMem: begin
          if (mem_ready_i) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    in_ready_o      = (state_q == StIdle);
    mem_valid_o     = 1'b0;
    mem_addr_o      = '0;
    mem_we_o        = 1'b0;
    mem_wdata_o     = '0;
    mem_id_o        = '0;
    out_valid_o     = 1'b0;
    out_op_o        = '0;
    out_rd_o        = '0;
    out_id_o        = '0;
    out_result_o    = '0;
    out_next_addr_o = '0;
    if (state_q == StMem) begin
      mem_valid_o = 1'b1;
      mem_addr_o  = req_q.addr;
      mem_we_o    = req_q.we;
      mem_wdata_o = wdata_q;
      mem_id_o    = id_q;
    end
    if (state_q == StDone) begin
      out_valid_o     = 1'b1;
      out_op_o        = op_q;
      out_rd_o        = rd_q;
      out_id_o        = id_q;
      out_result_o    = result_q;
      out_next_addr_o = next_addr_q;
    end
  end

endmodule

// File: tb/tb_fir_xifu_ex_simd.sv
// Scoreboard bench for fir_xifu_ex_simd: directed corner cases, then random
// transactions checked against a plain-arithmetic reference model.
module tb_fir_xifu_ex_simd;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned MAC_LAT = 3;
  localparam int unsigned ID_W    = 4;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            clear_i = 1'b0;
  logic            in_valid_i = 1'b0;
  logic            in_ready_o;
  logic [1:0]      in_op_i = '0;
  logic            in_mode_i = 1'b0;
  logic            in_sat_i = 1'b0;
  logic [ID_W-1:0] in_id_i = '0;
  logic [4:0]      in_rd_i = '0;
  logic [4:0]      in_rs1_i = '0;
  logic [XLEN-1:0] in_base_i = '0;
  logic [11:0]     in_imm_i = '0;
  logic [4:0]      in_shamt_i = '0;
  logic [XLEN-1:0] op_a_i = '0, op_b_i = '0, op_c_i = '0;
  logic            commit_valid_i = 1'b0;
  logic [ID_W-1:0] commit_id_i = '0;
  logic            commit_kill_i = 1'b0;
  logic            fwd_we_i = 1'b0;
  logic [4:0]      fwd_rd_i = '0;
  logic [XLEN-1:0] fwd_result_i = '0;
  logic            mem_valid_o;
  logic            mem_ready_i = 1'b1;
  logic [31:0]     mem_addr_o;
  logic            mem_we_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic [ID_W-1:0] mem_id_o;
  logic            out_valid_o;
  logic            out_ready_i = 1'b1;
  logic [1:0]      out_op_o;
  logic [4:0]      out_rd_o;
  logic [ID_W-1:0] out_id_o;
  logic [XLEN-1:0] out_result_o;
  logic [31:0]     out_next_addr_o;

  always #5 clk_i = ~clk_i;

  fir_xifu_ex_simd #(
    .XLEN   (XLEN),
    .MAC_LAT(MAC_LAT),
    .ID_W   (ID_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .clear_i        (clear_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_op_i        (in_op_i),
    .in_mode_i      (in_mode_i),
    .in_sat_i       (in_sat_i),
    .in_id_i        (in_id_i),
    .in_rd_i        (in_rd_i),
    .in_rs1_i       (in_rs1_i),
    .in_base_i      (in_base_i),
    .in_imm_i       (in_imm_i),
    .in_shamt_i     (in_shamt_i),
    .op_a_i         (op_a_i),
    .op_b_i         (op_b_i),
    .op_c_i         (op_c_i),
    .commit_valid_i (commit_valid_i),
    .commit_id_i    (commit_id_i),
    .commit_kill_i  (commit_kill_i),
    .fwd_we_i       (fwd_we_i),
    .fwd_rd_i       (fwd_rd_i),
    .fwd_result_i   (fwd_result_i),
    .mem_valid_o    (mem_valid_o),
    .mem_ready_i    (mem_ready_i),
    .mem_addr_o     (mem_addr_o),
    .mem_we_o       (mem_we_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_id_o       (mem_id_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_op_o       (out_op_o),
    .out_rd_o       (out_rd_o),
    .out_id_o       (out_id_o),
    .out_result_o   (out_result_o),
    .out_next_addr_o(out_next_addr_o)
  );

  typedef struct packed {
    logic [1:0]      op;
    logic [4:0]      rd;
    logic [ID_W-1:0] id;
    logic [31:0]     result;
    logic [31:0]     next_addr;
  } out_t;

  typedef struct packed {
    logic [31:0]     addr;
    logic            we;
    logic [31:0]     wdata;
    logic [ID_W-1:0] id;
  } mem_t;

  out_t out_q[$];
  mem_t mem_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   rand_ready = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on extracted lanes.
  function automatic logic [31:0] ref_dotp(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input logic mode,
                                           input logic sat);
    longint sum, ea, eb, one;
    int     w, lanes;
    one   = 1;
    w     = mode ? 8 : 16;
    lanes = 32 / w;
    sum   = longint'($signed(c));
    for (int i = 0; i < lanes; i++) begin
      ea = (longint'(a) >> (i * w)) & ((one << w) - 1);
      eb = (longint'(b) >> (i * w)) & ((one << w) - 1);
      if (ea >= (one << (w - 1))) ea -= (one << w);
      if (eb >= (one << (w - 1))) eb -= (one << w);
      sum += ea * eb;
    end
    if (sat) begin
      if (sum > 64'sd2147483647) sum = 64'sd2147483647;
      if (sum < -64'sd2147483648) sum = -64'sd2147483648;
    end
    return sum[31:0];
  endfunction

  function automatic logic [31:0] ref_shift(input logic [31:0] c, input logic [4:0] sh);
    longint v;
    v = longint'($signed(c));
    v = v >>> sh;
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_next(input logic [31:0] base, input logic [11:0] imm);
    longint v;
    v = longint'(base) + longint'($signed(imm));
    return v[31:0];
  endfunction

  always @(posedge clk_i) begin
    #1;
    if (rand_ready) begin
      out_ready_i = ($urandom_range(0, 3) != 0);
      mem_ready_i = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: checks held outputs stay stable and pops the scoreboard on each handshake.
  out_t held_out;
  mem_t held_mem;
  bit   out_held = 1'b0;
  bit   mem_held = 1'b0;

  always @(negedge clk_i) begin : monitor
    out_t cur_o, exp_o;
    mem_t cur_m, exp_m;
    cur_o = '{op: out_op_o, rd: out_rd_o, id: out_id_o, result: out_result_o,
              next_addr: out_next_addr_o};
    cur_m = '{addr: mem_addr_o, we: mem_we_o, wdata: mem_wdata_o, id: mem_id_o};
    if (out_valid_o && out_held) check("out_stable", 128'(cur_o), 128'(held_out));
    if (mem_valid_o && mem_held) check("mem_stable", 128'(cur_m), 128'(held_mem));
    if (out_valid_o && out_ready_i && !rst_i && !clear_i) begin
      if (out_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out_unexpected: got out handshake op=%0d id=%0d, required none",
                 out_op_o, out_id_o);
      end else begin
        exp_o = out_q.pop_front();
        check("out_op", 128'(cur_o.op), 128'(exp_o.op));
        check("out_rd", 128'(cur_o.rd), 128'(exp_o.rd));
        check("out_id", 128'(cur_o.id), 128'(exp_o.id));
        check("out_result", 128'(cur_o.result), 128'(exp_o.result));
        check("out_next_addr", 128'(cur_o.next_addr), 128'(exp_o.next_addr));
      end
    end
    if (mem_valid_o && mem_ready_i && !rst_i && !clear_i) begin
      if (mem_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL mem_unexpected: got mem handshake addr=%0h, required none", mem_addr_o);
      end else begin
        exp_m = mem_q.pop_front();
        check("mem_addr", 128'(cur_m.addr), 128'(exp_m.addr));
        check("mem_we", 128'(cur_m.we), 128'(exp_m.we));
        check("mem_wdata", 128'(cur_m.wdata), 128'(exp_m.wdata));
        check("mem_id", 128'(cur_m.id), 128'(exp_m.id));
      end
    end
    out_held = out_valid_o && !out_ready_i && !rst_i && !clear_i;
    mem_held = mem_valid_o && !mem_ready_i && !rst_i && !clear_i;
    held_out = cur_o;
    held_mem = cur_m;
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (!in_ready_o && n < 300) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    if (!in_ready_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got in_ready_o=0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic commit_noise(input logic [ID_W-1:0] id);
    commit_valid_i = 1'($urandom_range(0, 1));
    commit_id_i    = id ^ ID_W'($urandom_range(1, (1 << ID_W) - 1));
    commit_kill_i  = 1'($urandom_range(0, 1));
  endtask

  // Issues one instruction; returns #1 after the accept edge, or after the commit edge for a
  // store whose commit is delayed.
  task automatic issue(input logic [1:0] op, input logic mode, input logic sat,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [31:0] base, input logic [11:0] imm, input logic [4:0] sh,
                       input int cdelay, input bit kill, input bit fwd_hit,
                       input logic [31:0] fwd_val, input bit expect_any);
    logic [ID_W-1:0] id;
    logic [4:0]      rd, rs1;
    logic [31:0]     eff_base;
    out_t            eo;
    mem_t            em;
    wait_idle();
    id       = ID_W'($urandom);
    rd       = 5'($urandom);
    rs1      = 5'($urandom);
    eff_base = fwd_hit ? fwd_val : base;
    in_valid_i   = 1'b1;
    in_op_i      = op;
    in_mode_i    = mode;
    in_sat_i     = sat;
    in_id_i      = id;
    in_rd_i      = rd;
    in_rs1_i     = rs1;
    in_base_i    = base;
    in_imm_i     = imm;
    in_shamt_i   = sh;
    op_a_i       = a;
    op_b_i       = b;
    op_c_i       = c;
    fwd_we_i     = fwd_hit ? 1'b1 : 1'($urandom_range(0, 1));
    fwd_rd_i     = fwd_hit ? rs1 : rs1 ^ 5'($urandom_range(1, 31));
    fwd_result_i = fwd_val;
    if (expect_any && !(op == 2'd2 && kill)) begin
      eo = '{op: op, rd: rd, id: id, result: (op == 2'd3) ? ref_dotp(a, b, c, mode, sat) : '0,
             next_addr: (op == 2'd1 || op == 2'd2) ? ref_next(eff_base, imm) : '0};
      if (op == 2'd1 || op == 2'd2) begin
        em = '{addr: eff_base, we: (op == 2'd2), wdata: ref_shift(c, sh), id: id};
        mem_q.push_back(em);
      end
      out_q.push_back(eo);
    end
    if (op == 2'd2 && cdelay == 0) begin
      commit_valid_i = 1'b1;
      commit_id_i    = id;
      commit_kill_i  = 1'b0;
    end else begin
      commit_noise(id);
    end
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    fwd_we_i   = 1'b0;
    if (op == 2'd2) begin
      for (int k = 1; k <= cdelay; k++) begin
        check("store_wait_no_mem", 128'(mem_valid_o), 128'(0));
        if (k == cdelay) begin
          commit_valid_i = 1'b1;
          commit_id_i    = id;
          commit_kill_i  = kill;
        end else begin
          commit_noise(id);
        end
        @(posedge clk_i);
        #1;
      end
    end
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
    if (op == 2'd2 && kill) begin
      check("kill_in_ready", 128'(in_ready_o), 128'(1));
      check("kill_no_mem", 128'(mem_valid_o), 128'(0));
    end
  endtask

  task automatic measure_latency(input string name, input int exp_lat);
    int n;
    n = 1;
    while (!out_valid_o && n < 20) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    check(name, 128'(n), 128'(exp_lat));
  endtask

  task automatic check_quiet(input string name);
    check({name, "_in_ready"}, 128'(in_ready_o), 128'(1));
    check({name, "_out_valid"}, 128'(out_valid_o), 128'(0));
    check({name, "_mem_valid"}, 128'(mem_valid_o), 128'(0));
    check({name, "_outputs_zero"},
          128'({out_result_o, out_next_addr_o, mem_addr_o, mem_wdata_o, out_op_o, out_rd_o}),
          128'(0));
  endtask

  task automatic abort_dotp(input bit use_clear);
    issue(2'd3, 1'b0, 1'b0, 32'h1234_5678, 32'h9abc_def0, 32'd7, '0, '0, '0, 0, 1'b0, 1'b0,
          '0, 1'b0);
    @(posedge clk_i);
    #1;
    if (use_clear) clear_i = 1'b1;
    else rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i   = 1'b0;
    clear_i = 1'b0;
    check_quiet(use_clear ? "clear_mac" : "reset_mac");
    repeat (4) begin
      @(posedge clk_i);
      #1;
      check(use_clear ? "clear_no_out" : "reset_no_out", 128'(out_valid_o), 128'(0));
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got simulation still running, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin : main
    logic [1:0]  op;
    logic [31:0] a, b, c;
    int          cd;
    bit          kl;

    repeat (2) @(posedge clk_i);
    #1;
    check_quiet("reset");
    rst_i = 1'b0;

    // Latency and datapath corners with both readies held high.
    issue(2'd0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0, 0, 1'b0, 1'b0, '0, 1'b1);
    measure_latency("lat_nop", 1);
    issue(2'd3, 1'b0, 1'b0, 32'hFFFF_0002, 32'h0003_0004, 32'd10, '0, '0, '0, 0, 1'b0, 1'b0,
          '0, 1'b1);
    measure_latency("lat_dotp", MAC_LAT);
    check("dotp_lanes16", 128'(out_result_o), 128'(32'd15));
    issue(2'd1, 1'b0, 1'b0, '0, '0, 32'h5555_0000, 32'h0000_1000, 12'hFFC, 5'd3, 0, 1'b0,
          1'b1, 32'h0000_2000, 1'b1);
    check("load_fwd_addr", 128'(mem_addr_o), 128'(32'h0000_2000));
    check("load_we", 128'(mem_we_o), 128'(0));
    measure_latency("lat_load", 2);
    check("load_next_addr", 128'(out_next_addr_o), 128'(32'h0000_1FFC));
    issue(2'd3, 1'b1, 1'b1, 32'h7F7F_7F7F, 32'h7F7F_7F7F, 32'h7FFF_0000, '0, '0, '0, 0, 1'b0,
          1'b0, '0, 1'b1);
    issue(2'd3, 1'b1, 1'b0, 32'h7F7F_7F7F, 32'h7F7F_7F7F, 32'h7FFF_0000, '0, '0, '0, 0, 1'b0,
          1'b0, '0, 1'b1);
    issue(2'd3, 1'b1, 1'b1, 32'h7F7F_7F7F, 32'h8181_8181, 32'h8000_0010, '0, '0, '0, 0, 1'b0,
          1'b0, '0, 1'b1);
    issue(2'd3, 1'b0, 1'b1, 32'h7FFF_7FFF, 32'h7FFF_7FFF, 32'h7FFF_FFF0, '0, '0, '0, 0, 1'b0,
          1'b0, '0, 1'b1);

    // Store held until commit, then stalled by the LSU for two cycles.
    wait_idle();
    mem_ready_i = 1'b0;
    issue(2'd2, 1'b0, 1'b0, '0, '0, 32'hFFFF_FF00, 32'h0000_0400, 12'h010, 5'd4, 3, 1'b0,
          1'b0, '0, 1'b1);
    check("store_mem_valid", 128'(mem_valid_o), 128'(1));
    check("store_wdata", 128'(mem_wdata_o), 128'(32'hFFFF_FFF0));
    check("store_we", 128'(mem_we_o), 128'(1));
    repeat (2) begin
      @(posedge clk_i);
      #1;
      check("store_stall_no_out", 128'(out_valid_o), 128'(0));
    end
    mem_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("store_out_after_ready", 128'(out_valid_o), 128'(1));

    // Killed store, then aborted DOTPs.
    issue(2'd2, 1'b0, 1'b0, '0, '0, 32'h1, 32'h40, '0, '0, 2, 1'b1, 1'b0, '0, 1'b1);
    repeat (3) begin
      @(posedge clk_i);
      #1;
      check("kill_quiet", 128'({mem_valid_o, out_valid_o}), 128'(0));
    end
    abort_dotp(1'b0);
    abort_dotp(1'b1);

    // Clear wins over a simultaneous LSU handshake.
    mem_ready_i = 1'b0;
    issue(2'd1, 1'b0, 1'b0, '0, '0, '0, 32'h300, 12'h004, '0, 0, 1'b0, 1'b0, '0, 1'b0);
    clear_i     = 1'b1;
    mem_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    clear_i = 1'b0;
    check_quiet("clear_vs_mem_ready");

    rand_ready = 1'b1;
    for (int t = 0; t < 300; t++) begin
      op = 2'($urandom_range(0, 3));
      a  = (t % 7 == 0) ? 32'h8000_8000 : $urandom;
      b  = (t % 5 == 0) ? 32'h7FFF_8001 : $urandom;
      c  = (t % 3 == 0) ? {1'($urandom_range(0, 1)), 31'h7FFF_FFF0} : $urandom;
      kl = ($urandom_range(0, 4) == 0);
      cd = kl ? $urandom_range(1, 3) : $urandom_range(0, 3);
      issue(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, b, c, $urandom,
            12'($urandom), 5'($urandom), cd, kl, ($urandom_range(0, 1) == 1), $urandom, 1'b1);
    end

    rand_ready = 1'b0;
    #2;
    out_ready_i = 1'b1;
    mem_ready_i = 1'b1;
    for (int n = 0; n < 50 && (out_q.size() + mem_q.size()) != 0; n++) @(posedge clk_i);
    repeat (2) @(posedge clk_i);
    check("queues_drained", 128'(out_q.size() + mem_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
